interlock_unit: RTL



---
 rtl/pipe_pkg.sv | 72 +++++++
 rtl/ir_reg_usage.sv | 66 ++++++
 rtl/interlock_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, IR field positions and register-usage classes.
package pipe_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_LSL  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_NOP  = 5'd13;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BGT  = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;
  localparam logic [4:0] OP_HLT  = 5'd31;

  localparam logic [31:0] NOP_IR = 32'h6800_0000;
  localparam logic [3:0]  R15    = 4'd15;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int I_BIT   = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 22;
  localparam int RS1_MSB = 21;
  localparam int RS1_LSB = 18;
  localparam int RS2_MSB = 17;
  localparam int RS2_LSB = 14;

  typedef enum logic [2:0] {
    SRC_NONE, SRC_BIN, SRC_UNARY, SRC_RS1, SRC_RS1_RD, SRC_R15
  } src_class_e;

  typedef enum logic [1:0] {DST_NONE, DST_RD, DST_R15} dst_class_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] rg;
  } sb_entry_t;

  function automatic src_class_e src_class(input logic [4:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR,
      OP_LSL, OP_LSR, OP_ASR, OP_CMP: return SRC_BIN;
      OP_NOT, OP_MOV:                 return SRC_UNARY;
      OP_LD:                          return SRC_RS1;
      OP_ST:                          return SRC_RS1_RD;
      OP_RET:                         return SRC_R15;
      default:                        return SRC_NONE;
    endcase
  endfunction

  function automatic dst_class_e dst_class(input logic [4:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_NOT,
      OP_MOV, OP_LSL, OP_LSR, OP_ASR, OP_LD: return DST_RD;
      OP_CALL:                               return DST_R15;
      default:                               return DST_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ir_reg_usage.sv
// Decodes which registers the OF instruction reads and writes.
module ir_reg_usage
  import pipe_pkg::*;
(
  input  logic [31:0] of_ir,
  output logic        src1_v,
  output logic [3:0]  src1,
  output logic        src2_v,
  output logic [3:0]  src2,
  output logic        dst_v,
  output logic [3:0]  dst
);

  logic [4:0]  opc;
  logic        imm;
  logic [3:0]  rd, rs1, rs2;
  logic [13:0] unused_bits;
  src_class_e  sc;
  dst_class_e  dc;

  assign opc         = of_ir[OPC_MSB:OPC_LSB];
  assign imm         = of_ir[I_BIT];
  assign rd          = of_ir[RD_MSB:RD_LSB];
  assign rs1         = of_ir[RS1_MSB:RS1_LSB];
  assign rs2         = of_ir[RS2_MSB:RS2_LSB];
  assign unused_bits = of_ir[13:0];
  assign sc          = src_class(opc);
  assign dc          = dst_class(opc);

  always_comb begin
    src1_v = 1'b0;
    src1   = rs1;
    src2_v = 1'b0;
    src2   = rs2;
    dst_v  = 1'b0;
    dst    = rd;
    case (sc)
      SRC_BIN: begin
        src1_v = 1'b1;
        src2_v = ~imm;
      end
      SRC_UNARY: src2_v = ~imm;
      SRC_RS1:   src1_v = 1'b1;
      // A store reads its data register through the rd field.
      SRC_RS1_RD: begin
        src1_v = 1'b1;
        src2_v = 1'b1;
        src2   = rd;
      end
      SRC_R15: begin
        src1_v = 1'b1;
        src1   = R15;
      end
      default: ;
    endcase
    case (dc)
      DST_RD:  dst_v = 1'b1;
      DST_R15: begin
        dst_v = 1'b1;
        dst   = R15;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/interlock_unit.sv
// RAW-stall and branch-flush interlock generator for the OF/EX latch,
// with a 3-deep destination scoreboard and saturating event counters.
module interlock_unit
  import pipe_pkg::*;
#(
  parameter int BRANCH_BUBBLES = 2,
  parameter bit RW_BYPASS      = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      of_ir,
  input  logic             ex_branch_taken,
  output logic             isDataInterLock,
  output logic             isBranchInterLock,
  output logic             pc_stall,
  output logic [CNT_W-1:0] data_stall_count,
  output logic [CNT_W-1:0] branch_flush_count
);

  localparam int BCNT_W = (BRANCH_BUBBLES > 1) ? $clog2(BRANCH_BUBBLES) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LOAD = BCNT_W'(BRANCH_BUBBLES - 1);

  sb_entry_t         ex_q, ma_q, rw_q, ex_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d, fcnt_q, fcnt_d;

  logic       src1_v, src2_v, dst_v;
  logic [3:0] src1, src2, dst;
  logic [1:0] src_v;
  logic [3:0] src_r [2];
  logic [1:0] src_hit;
  logic       data_hazard;

  ir_reg_usage u_usage (
    .of_ir  (of_ir),
    .src1_v (src1_v),
    .src1   (src1),
    .src2_v (src2_v),
    .src2   (src2),
    .dst_v  (dst_v),
    .dst    (dst)
  );

  assign src_v    = {src2_v, src1_v};
  assign src_r[0] = src1;
  assign src_r[1] = src2;

  // With the regfile writing before it is read, the RW stage never blocks.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
      logic hit_rw;
      assign hit_rw = RW_BYPASS ? 1'b0 : (rw_q.valid && rw_q.rg == src_r[gi]);
      assign src_hit[gi] = src_v[gi] &&
                           ((ex_q.valid && ex_q.rg == src_r[gi]) ||
                            (ma_q.valid && ma_q.rg == src_r[gi]) || hit_rw);
    end
  endgenerate

  assign data_hazard        = |src_hit;
  assign isBranchInterLock  = ex_branch_taken | (bcnt_q != '0);
  assign isDataInterLock    = data_hazard & ~isBranchInterLock;
  assign pc_stall           = isDataInterLock;
  assign data_stall_count   = dcnt_q;
  assign branch_flush_count = fcnt_q;

  always_comb begin
    ex_d = '{valid: dst_v, rg: dst};
    if (isDataInterLock || isBranchInterLock) ex_d.valid = 1'b0;

    bcnt_d = bcnt_q;
    if (ex_branch_taken && bcnt_q == '0) bcnt_d = BCNT_LOAD;
    else if (bcnt_q != '0)               bcnt_d = bcnt_q - 1'b1;

    dcnt_d = (isDataInterLock && !(&dcnt_q)) ? dcnt_q + 1'b1 : dcnt_q;
    fcnt_d = (isBranchInterLock && !(&fcnt_q)) ? fcnt_q + 1'b1 : fcnt_q;
  end

  // State moves on the falling edge, in step with the pipeline latches.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      ex_q   <= '0;
      ma_q   <= '0;
      rw_q   <= '0;
      bcnt_q <= '0;
      dcnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      ex_q   <= ex_d;
      ma_q   <= ex_q;
      rw_q   <= ma_q;
      bcnt_q <= bcnt_d;
      dcnt_q <= dcnt_d;
      fcnt_q <= fcnt_d;
    end
  end

endmodule
